// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg
//   Shared constants for the SPI command frontend: command opcodes, FSM state
//   encodings, status-byte bit positions and small saturation helpers.
//   Optional feature macro used by the including modules: SPI_CMD_CHECKSUM_EN.
package spi_cmd_pkg;

    // Command byte: [7:4] opcode, [3:0] channel
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_STATUS = 4'h1;
    localparam logic [3:0] OP_WRITE  = 4'h2;
    localparam logic [3:0] OP_CLEAR  = 4'h3;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STAT  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_SKIP  = 2'd3;

    // Status byte layout: {overflow[sel], bad_cmd, chksum_err, free_slots[4:0]}
    localparam int STB_OVF     = 7;
    localparam int STB_BAD     = 6;
    localparam int STB_CHK     = 5;
    localparam int STB_SLOTS_W = 5;

    function automatic logic [7:0] sat_u8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [STB_SLOTS_W-1:0] sat_slots(input logic [31:0] v);
        return (v > 32'd31) ? 5'h1F : v[STB_SLOTS_W-1:0];
    endfunction

endpackage

// File: rtl/record_assembler.sv
// record_assembler
//   Collects RECORD_WORDS SPI words into one record (first word ends up in the
//   MSBs). With SPI_CMD_CHECKSUM_EN defined, one more word follows each record
//   and must equal the XOR of the record words.
// Ports
//   clk, reset   clock, synchronous active-high reset
//   clear        discard the partial record (chip select deasserted)
//   en           word strobe, only asserted while the FSM is in WRITE
//   word         incoming SPI word
//   rec_done     combinational: this strobe completes the record (or checksum)
//   rec_ok       combinational: checksum matches (always 1 without checksum)
//   record       combinational: full record, valid while rec_done is high
// The assembler clears itself on rec_done, so the caller must capture record
// in that same cycle.
module record_assembler import spi_cmd_pkg::*; #(
    parameter int WORD_SIZE    = 8,
    parameter int RECORD_WORDS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              en,
    input  logic [WORD_SIZE-1:0]              word,
    output logic                              rec_done,
    output logic                              rec_ok,
    output logic [WORD_SIZE*RECORD_WORDS-1:0] record
);

    localparam int CNT_W = $clog2(RECORD_WORDS + 2);

`ifdef SPI_CMD_CHECKSUM_EN
    // All record words are held; the final strobe carries the checksum.
    localparam int             SH_W     = WORD_SIZE * RECORD_WORDS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RECORD_WORDS);
`else
    // The final record word is taken straight from the input, so one word less is stored.
    localparam int             SH_W     = WORD_SIZE * (RECORD_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RECORD_WORDS - 1);
`endif

    logic [CNT_W-1:0] cnt;
    logic [SH_W-1:0]  shreg;

    assign rec_done = en && (cnt == LAST_CNT);

`ifdef SPI_CMD_CHECKSUM_EN
    logic [WORD_SIZE-1:0] acc;

    assign record = shreg;
    assign rec_ok = (acc == word);

    always_ff @(posedge clk) begin
        if (reset || clear || rec_done) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ word;
        end
    end
`else
    assign record = {shreg, word};
    assign rec_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset || clear || rec_done) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (en) begin
            cnt   <= cnt + 1'b1;
            // Truncating cast drops the oldest word off the top.
            shreg <= SH_W'({shreg, word});
        end
    end

endmodule

// File: rtl/spi_cmd_frontend.sv
// spi_cmd_frontend
//   Decodes SPI command bytes and streams fixed-size records into one of
//   NUM_CHANNELS record FIFOs, with sticky error flags and a status byte
//   returned over MISO.
//   Optional feature: SPI_CMD_CHECKSUM_EN adds a per-record XOR checksum word.
// Ports
//   clk, reset        clock, synchronous active-high reset
//   spi_cs            chip select, active low (already synchronised)
//   rx_word/rx_valid  received SPI word and its one-cycle strobe
//   tx_word           word returned on the next SPI transfer (registered)
//   fifo_free_slots   NUM_CHANNELS lanes of SLOTS_W free-slot counts
//   fifo_full         per-channel full
//   fifo_wr_en        one-hot, one-cycle record push
//   fifo_wr_data      pushed record, first received word in the MSBs
//   overflow          sticky per channel: record dropped on a full FIFO
//   bad_cmd           sticky: illegal opcode or channel
//   chksum_err        sticky: checksum mismatch (0 without the checksum feature)
//   drop_count        saturating count of dropped records
//   busy              FSM not idle
module spi_cmd_frontend import spi_cmd_pkg::*; #(
    parameter int WORD_SIZE    = 8,
    parameter int RECORD_WORDS = 4,
    parameter int NUM_CHANNELS = 2,
    parameter int SLOTS_W      = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              spi_cs,
    input  logic [WORD_SIZE-1:0]              rx_word,
    input  logic                              rx_valid,
    output logic [WORD_SIZE-1:0]              tx_word,
    input  logic [NUM_CHANNELS*SLOTS_W-1:0]   fifo_free_slots,
    input  logic [NUM_CHANNELS-1:0]           fifo_full,
    output logic [NUM_CHANNELS-1:0]           fifo_wr_en,
    output logic [WORD_SIZE*RECORD_WORDS-1:0] fifo_wr_data,
    output logic [NUM_CHANNELS-1:0]           overflow,
    output logic                              bad_cmd,
    output logic                              chksum_err,
    output logic [7:0]                        drop_count,
    output logic                              busy
);

    localparam int REC_W = WORD_SIZE * RECORD_WORDS;

    logic                    rx;
    logic [1:0]              state_q, state_d;
    logic [3:0]              sel_q, sel_d;
    logic [NUM_CHANNELS-1:0] ovf_q, sel_oh;
    logic                    bad_q, chk_bit;
    logic [7:0]              drop_q;
    logic [NUM_CHANNELS-1:0] wr_en_q;
    logic [REC_W-1:0]        wr_data_q;
    logic [WORD_SIZE-1:0]    tx_q, tx_d;

    logic                    rec_done, rec_ok;
    logic [REC_W-1:0]        rec;
    logic                    set_bad, do_clear, push, drop_ovf, drop_chk;

    // Channel-indexed views padded to the full 4-bit channel space so sel can
    // index them directly; entries beyond NUM_CHANNELS read as zero.
    logic [15:0][SLOTS_W-1:0] slots_arr;
    logic [15:0]              full_ext, ovf_ext;

    assign full_ext = 16'(fifo_full);
    assign ovf_ext  = 16'(ovf_q);

    for (genvar g = 0; g < 16; g++) begin : g_slots
        if (g < NUM_CHANNELS) begin : g_used
            assign slots_arr[g] = fifo_free_slots[g*SLOTS_W +: SLOTS_W];
        end else begin : g_pad
            assign slots_arr[g] = '0;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_oh
        assign sel_oh[g] = (sel_q == 4'(g));
    end

    // A strobe is only meaningful while the part is selected.
    assign rx = rx_valid & ~spi_cs;

    record_assembler #(
        .WORD_SIZE    (WORD_SIZE),
        .RECORD_WORDS (RECORD_WORDS)
    ) u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (spi_cs),
        .en       (rx && (state_q == ST_WRITE)),
        .word     (rx_word),
        .rec_done (rec_done),
        .rec_ok   (rec_ok),
        .record   (rec)
    );

    // Next-state / action decode
    always_comb begin
        logic [3:0] op, ch;
        op       = rx_word[7:4];
        ch       = rx_word[3:0];
        state_d  = state_q;
        sel_d    = sel_q;
        set_bad  = 1'b0;
        do_clear = 1'b0;
        push     = 1'b0;
        drop_ovf = 1'b0;
        drop_chk = 1'b0;
        if (rx) begin
            case (state_q)
                ST_IDLE: begin
                    if ((32'(ch) >= NUM_CHANNELS) || (op > OP_CLEAR)) begin
                        set_bad = 1'b1;
                        state_d = ST_SKIP;
                    end else begin
                        case (op)
                            OP_STATUS: begin sel_d = ch; state_d = ST_STAT;  end
                            OP_WRITE:  begin sel_d = ch; state_d = ST_WRITE; end
                            OP_CLEAR:  begin sel_d = ch; do_clear = 1'b1;    end
                            default:   ;
                        endcase
                    end
                end
                ST_STAT:  state_d = ST_IDLE;
                ST_WRITE: begin
                    // A bad checksum takes precedence over a full FIFO.
                    if (rec_done) begin
                        if (!rec_ok)                drop_chk = 1'b1;
                        else if (full_ext[sel_q])   drop_ovf = 1'b1;
                        else                        push     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (spi_cs) state_d = ST_IDLE;
    end

    // tx_word reflects where this word leaves the FSM, so the STATUS command
    // itself loads the status byte for the following transfer.
    always_comb begin
        logic [7:0] stat;
        stat = 8'h00;
        stat[STB_OVF] = ovf_ext[sel_d];
        stat[STB_BAD] = bad_q;
        stat[STB_CHK] = chk_bit;
        stat[STB_SLOTS_W-1:0] = sat_slots(32'(slots_arr[sel_d]));
        tx_d = (state_d == ST_STAT) ? stat : sat_u8(32'(slots_arr[sel_d]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            ovf_q     <= '0;
            bad_q     <= 1'b0;
            drop_q    <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            tx_q      <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wr_en_q <= '0;
            if (push) begin
                wr_en_q   <= sel_oh;
                wr_data_q <= rec;
            end
            if (set_bad) bad_q <= 1'b1;
            if (do_clear) begin
                ovf_q  <= '0;
                bad_q  <= 1'b0;
                drop_q <= '0;
            end
            if (drop_ovf) ovf_q <= ovf_q | sel_oh;
            if ((drop_ovf || drop_chk) && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
            if (rx) tx_q <= tx_d;
        end
    end

`ifdef SPI_CMD_CHECKSUM_EN
    logic chk_q;

    always_ff @(posedge clk) begin
        if (reset)         chk_q <= 1'b0;
        else if (do_clear) chk_q <= 1'b0;
        else if (drop_chk) chk_q <= 1'b1;
    end

    assign chk_bit = chk_q;
`else
    assign chk_bit = 1'b0;
`endif

    assign tx_word      = tx_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign overflow     = ovf_q;
    assign bad_cmd      = bad_q;
    assign chksum_err   = chk_bit;
    assign drop_count   = drop_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
